// File: rtl/usr_seq_ctrl_if.sv
// Command handshake bundle between a command source and the shift-register sequencer.
interface usr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD;
  logic             CMD_DIR;
  logic [CNT_W-1:0] CMD_COUNT;
  logic [WIDTH-1:0] CMD_DATA;
  logic             CMD_SERIAL;

  modport master (
    output CMD_VALID, CMD, CMD_DIR, CMD_COUNT, CMD_DATA, CMD_SERIAL,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD, CMD_DIR, CMD_COUNT, CMD_DATA, CMD_SERIAL,
    output CMD_READY
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register: issues clear, load and
// counted shift/rotate steps as one-cycle update enables on the common clock.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  usr_seq_ctrl_if.slave    cmd_if,
  input  logic             STEP_MODE,
  input  logic             SWITCH,
  input  logic             ABORT,
  input  logic             USR_SERIAL_OUT,
  output logic             USR_CLR,
  output logic             USR_PARALLEL_MODE,
  output logic             USR_SHIFT_RIGHT,
  output logic             USR_SERIAL_INPUT,
  output logic [WIDTH-1:0] USR_PARALLEL_INPUT,
  output logic             USR_STEP,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] REMAINING
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StLoad  = 3'd2,
    StSwait = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e           r_state;
  logic             r_step;
  logic             r_clr;
  logic             r_pmode;
  logic             r_done;
  logic             r_busy;
  logic             r_dir;
  logic             r_serial;
  logic             r_rot;
  logic             r_step_mode;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_rem;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_edge;
  logic             w_abort_now;

  // Synchronise the raw switch and register a single-cycle rising-edge flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= SWITCH;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Main FSM; outputs for the next state are registered alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= StIdle;
      r_step      <= 1'b0;
      r_clr       <= 1'b0;
      r_pmode     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_dir       <= 1'b0;
      r_serial    <= 1'b0;
      r_rot       <= 1'b0;
      r_step_mode <= 1'b0;
      r_data      <= '0;
      r_rem       <= '0;
    end else begin
      r_step  <= 1'b0;
      r_clr   <= 1'b0;
      r_pmode <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_if.CMD_VALID) begin
            r_dir       <= cmd_if.CMD_DIR;
            r_serial    <= cmd_if.CMD_SERIAL;
            r_rot       <= cmd_if.CMD[0];
            r_step_mode <= STEP_MODE;
            r_data      <= cmd_if.CMD_DATA;
            r_busy      <= 1'b1;
            case (cmd_if.CMD)
              2'b00: begin
                r_state <= StClr;
                r_clr   <= 1'b1;
                r_step  <= 1'b1;
              end
              2'b01: begin
                r_state <= StLoad;
                r_pmode <= 1'b1;
                r_step  <= 1'b1;
              end
              default: begin
                r_rem <= cmd_if.CMD_COUNT;
                if (cmd_if.CMD_COUNT == '0) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
                end else if (STEP_MODE) begin
                  r_state <= StSwait;
                end else begin
                  r_state <= StShift;
                  r_step  <= 1'b1;
                end
              end
            endcase
          end
        end
        StClr, StLoad: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StSwait: begin
          if (ABORT) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_rem   <= '0;
          end else if (r_edge) begin
            r_state <= StShift;
            r_step  <= 1'b1;
          end
        end
        StShift: begin
          if (ABORT) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_rem   <= '0;
          end else begin
            r_rem <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else if (r_step_mode) begin
              r_state <= StSwait;
            end else begin
              r_step <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_rem   <= '0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // An abort landing in a shift cycle must suppress that cycle's register update.
  assign w_abort_now = ABORT && (r_state == StShift);

  // Output decode: ready follows reset release immediately; rotate feeds back combinationally.
  always_comb begin
    cmd_if.CMD_READY   = RST && (r_state == StIdle);
    USR_STEP           = r_step & ~w_abort_now;
    USR_CLR            = r_clr;
    USR_PARALLEL_MODE  = r_pmode;
    USR_SHIFT_RIGHT    = r_dir;
    USR_PARALLEL_INPUT = r_data;
    USR_SERIAL_INPUT   = 1'b0;
    if (r_state == StShift) begin
      USR_SERIAL_INPUT = r_rot ? USR_SERIAL_OUT : r_serial;
    end
    BUSY      = r_busy;
    DONE      = r_done;
    REMAINING = r_rem;
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl with a behavioural model of the 4-bit shift register.
module tb_usr_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       STEP_MODE;
  logic       SWITCH;
  logic       ABORT;
  logic       USR_SERIAL_OUT;
  logic       USR_CLR;
  logic       USR_PARALLEL_MODE;
  logic       USR_SHIFT_RIGHT;
  logic       USR_SERIAL_INPUT;
  logic [3:0] USR_PARALLEL_INPUT;
  logic       USR_STEP;
  logic       BUSY;
  logic       DONE;
  logic [2:0] REMAINING;
  logic [3:0] model_q;

  int n_pass  = 0;
  int n_total = 0;
  int cnt;
  int dcnt;

  usr_seq_ctrl_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .cmd_if             (cmd_if),
    .STEP_MODE          (STEP_MODE),
    .SWITCH             (SWITCH),
    .ABORT              (ABORT),
    .USR_SERIAL_OUT     (USR_SERIAL_OUT),
    .USR_CLR            (USR_CLR),
    .USR_PARALLEL_MODE  (USR_PARALLEL_MODE),
    .USR_SHIFT_RIGHT    (USR_SHIFT_RIGHT),
    .USR_SERIAL_INPUT   (USR_SERIAL_INPUT),
    .USR_PARALLEL_INPUT (USR_PARALLEL_INPUT),
    .USR_STEP           (USR_STEP),
    .BUSY               (BUSY),
    .DONE               (DONE),
    .REMAINING          (REMAINING)
  );

  always #5 CLK = ~CLK;

  // Shift register model clocked by the common clock and gated by USR_STEP.
  initial model_q = 4'b0000;
  always @(posedge CLK) begin
    if (USR_STEP) begin
      if (USR_CLR)                model_q <= 4'b0000;
      else if (USR_PARALLEL_MODE) model_q <= USR_PARALLEL_INPUT;
      else if (USR_SHIFT_RIGHT)   model_q <= {USR_SERIAL_INPUT, model_q[3:1]};
      else                        model_q <= {model_q[2:0], USR_SERIAL_INPUT};
    end
  end
  assign USR_SERIAL_OUT = USR_SHIFT_RIGHT ? model_q[0] : model_q[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command and pass the acceptance edge; returns 1 ns into cycle 1.
  task automatic send(input logic [1:0] c, input logic dir, input logic [2:0] n,
                      input logic [3:0] d, input logic ser);
    cmd_if.CMD        = c;
    cmd_if.CMD_DIR    = dir;
    cmd_if.CMD_COUNT  = n;
    cmd_if.CMD_DATA   = d;
    cmd_if.CMD_SERIAL = ser;
    cmd_if.CMD_VALID  = 1'b1;
    tick();
    cmd_if.CMD_VALID  = 1'b0;
  endtask

  initial begin
    RST = 1'b0; STEP_MODE = 1'b0; SWITCH = 1'b0; ABORT = 1'b0;
    cmd_if.CMD_VALID = 1'b0; cmd_if.CMD = 2'b00; cmd_if.CMD_DIR = 1'b0;
    cmd_if.CMD_COUNT = 3'd0; cmd_if.CMD_DATA = 4'h0; cmd_if.CMD_SERIAL = 1'b0;
    tick(); tick();
    chk("rst_step", USR_STEP, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_rem", REMAINING, 3'd0);
    chk("rst_pin", USR_PARALLEL_INPUT, 4'h0);
    #2 RST = 1'b1;
    #1 chk("rst_ready", cmd_if.CMD_READY, 1'b1);
    tick();

    // LOAD 1011
    send(2'b01, 1'b0, 3'd0, 4'b1011, 1'b0);
    cmd_if.CMD_DATA = 4'b0000;
    chk("ld_step", USR_STEP, 1'b1);
    chk("ld_pmode", USR_PARALLEL_MODE, 1'b1);
    chk("ld_pin", USR_PARALLEL_INPUT, 4'b1011);
    chk("ld_ready1", cmd_if.CMD_READY, 1'b0);
    chk("ld_busy", BUSY, 1'b1);
    tick();
    chk("ld_done", DONE, 1'b1);
    chk("ld_step2", USR_STEP, 1'b0);
    chk("ld_ready2", cmd_if.CMD_READY, 1'b0);
    tick();
    chk("ld_done_end", DONE, 1'b0);
    chk("ld_ready3", cmd_if.CMD_READY, 1'b1);
    chk("ld_model", model_q, 4'b1011);
    chk("ld_hold_pin", USR_PARALLEL_INPUT, 4'b1011);

    // Free-run SHIFT right, count 3, serial 1; later input changes must not matter
    send(2'b10, 1'b1, 3'd3, 4'h0, 1'b1);
    cmd_if.CMD_SERIAL = 1'b0; cmd_if.CMD_DIR = 1'b0; cmd_if.CMD_COUNT = 3'd7;
    for (int i = 0; i < 3; i++) begin
      chk("sh_step", USR_STEP, 1'b1);
      chk("sh_right", USR_SHIFT_RIGHT, 1'b1);
      chk("sh_sin", USR_SERIAL_INPUT, 1'b1);
      chk("sh_rem", REMAINING, 3'(3 - i));
      chk("sh_nodone", DONE, 1'b0);
      tick();
    end
    chk("sh_done", DONE, 1'b1);
    chk("sh_step_off", USR_STEP, 1'b0);
    chk("sh_rem0", REMAINING, 3'd0);
    chk("sh_model", model_q, 4'b1111);
    tick();
    chk("sh_idle", BUSY, 1'b0);

    // LOAD 1000 then ROTATE left 4
    send(2'b01, 1'b0, 3'd0, 4'b1000, 1'b0);
    tick(); tick();
    chk("rot_pre", model_q, 4'b1000);
    send(2'b11, 1'b0, 3'd4, 4'b1000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_sin;
      exp_sin = 4'b0001;
      chk("rot_step", USR_STEP, 1'b1);
      chk("rot_sin", USR_SERIAL_INPUT, exp_sin[i]);
      tick();
    end
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (DONE) dcnt++;
      tick();
    end
    chk("rot_done_cnt", dcnt, 1);
    chk("rot_model", model_q, 4'b1000);

    // Step mode: glitch while idle must be ignored
    SWITCH = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (USR_STEP) cnt++; end
    SWITCH = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (USR_STEP) cnt++; end
    chk("sw_idle_glitch", cnt, 0);
    chk("sw_idle_busy", BUSY, 1'b0);
    STEP_MODE = 1'b1;
    send(2'b10, 1'b1, 3'd2, 4'h0, 1'b0);
    STEP_MODE = 1'b0;
    tick(); tick();
    chk("sw_wait_step", USR_STEP, 1'b0);
    chk("sw_wait_busy", BUSY, 1'b1);
    chk("sw_wait_rem", REMAINING, 3'd2);
    SWITCH = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (USR_STEP) cnt++; end
    chk("sw_edge1_steps", cnt, 1);
    chk("sw_rem1", REMAINING, 3'd1);
    SWITCH = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (USR_STEP) cnt++; end
    chk("sw_low_steps", cnt, 0);
    chk("sw_low_done", DONE, 1'b0);
    SWITCH = 1'b1;
    cnt = 0; dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (USR_STEP) cnt++;
      if (DONE) dcnt++;
    end
    chk("sw_edge2_steps", cnt, 1);
    chk("sw_done_cnt", dcnt, 1);
    SWITCH = 1'b0;
    tick();
    chk("sw_end_idle", cmd_if.CMD_READY, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // SHIFT count 0
    send(2'b10, 1'b0, 3'd0, 4'h0, 1'b0);
    chk("z_step", USR_STEP, 1'b0);
    chk("z_done", DONE, 1'b1);
    chk("z_busy", BUSY, 1'b1);
    tick();
    chk("z_ready", cmd_if.CMD_READY, 1'b1);

    // CLEAR
    send(2'b00, 1'b0, 3'd0, 4'h0, 1'b0);
    chk("clr_clr", USR_CLR, 1'b1);
    chk("clr_step", USR_STEP, 1'b1);
    tick();
    chk("clr_clr_off", USR_CLR, 1'b0);
    chk("clr_done", DONE, 1'b1);
    chk("clr_model", model_q, 4'b0000);
    tick();

    // Free-run count 7 with abort after 2 steps
    send(2'b10, 1'b0, 3'd7, 4'h0, 1'b1);
    tick(); tick();
    ABORT = 1'b1;
    #1 chk("ab_step_gated", USR_STEP, 1'b0);
    tick();
    ABORT = 1'b0;
    chk("ab_busy", BUSY, 1'b0);
    chk("ab_rem", REMAINING, 3'd0);
    chk("ab_ready", cmd_if.CMD_READY, 1'b1);
    chk("ab_model", model_q, 4'b0011);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin if (DONE || USR_STEP) dcnt++; tick(); end
    chk("ab_quiet", dcnt, 0);

    // Free-run count 7 with reset mid-shift
    send(2'b10, 1'b0, 3'd7, 4'h0, 1'b1);
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("mr_step", USR_STEP, 1'b0);
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_rem", REMAINING, 3'd0);
    chk("mr_done", DONE, 1'b0);
    tick();
    RST = 1'b1;
    #1 chk("mr_ready", cmd_if.CMD_READY, 1'b1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (USR_STEP || DONE) cnt++; end
    chk("mr_quiet", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command sequencer for the 4-bit universal shift register. It accepts CLEAR, LOAD, SHIFT and ROTATE commands over a valid/ready handshake. It drives the register's mode, data and clear inputs, plus a one-cycle step enable (USR_STEP) that gates the register's update on the common CLK. Shifts either free-run at one position per clock or single-step on rising edges of a board switch, replacing the switch-derived clock with a synchronous enable.

Parameters:
WIDTH, 4, parallel word width to and from the shift register
CNT_W, 3, shift-count width; the maximum shift per command is 2^CNT_W-1

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RST  in  1  asynchronous, active-low reset
CMD_VALID  in  1  command present
CMD_READY  out  1  controller can accept a command
CMD  in  2  00 CLEAR, 01 LOAD, 10 SHIFT, 11 ROTATE
CMD_DIR  in  1  1 = shift right, 0 = shift left
CMD_COUNT  in  CNT_W  number of positions to shift (SHIFT/ROTATE)
CMD_DATA  in  WIDTH  word to load (LOAD)
CMD_SERIAL  in  1  fill bit for SHIFT
STEP_MODE  in  1  1 = wait for a SWITCH rising edge before each shift
SWITCH  in  1  raw asynchronous switch input
ABORT  in  1  synchronous abort of a shift in progress
USR_SERIAL_OUT  in  1  serial output of the shift register (used for ROTATE)
USR_CLR  out  1  clear request to the register
USR_PARALLEL_MODE  out  1  1 = parallel load
USR_SHIFT_RIGHT  out  1  shift direction
USR_SERIAL_INPUT  out  1  serial fill bit
USR_PARALLEL_INPUT  out  WIDTH  load word
USR_STEP  out  1  one-cycle register update enable
BUSY  out  1  state is not IDLE
DONE  out  1  one-cycle pulse when a command completes
REMAINING  out  CNT_W  shifts still outstanding

Behaviour:
- Reset (RST=0, asynchronous): state IDLE. All USR_* outputs 0, DONE=0, BUSY=0, REMAINING=0, synchroniser flops 0. CMD_READY=1 once RST=1.
- Command acceptance: CMD_VALID & CMD_READY at a rising edge. CMD_READY=1 only in IDLE.
- Latched at acceptance: CMD, CMD_DIR, CMD_COUNT, CMD_DATA, CMD_SERIAL and STEP_MODE. Later input changes have no effect until the next acceptance.
- States: IDLE, CLR, LOAD, SWAIT, SHIFT, DONE.
- IDLE transitions on acceptance:
  - CLEAR -> CLR
  - LOAD -> LOAD
  - SHIFT/ROTATE with count 0 -> DONE (no step issued)
  - SHIFT/ROTATE with count >0 and step mode -> SWAIT
  - SHIFT/ROTATE with count >0 and free-run -> SHIFT
- CLR: USR_CLR=1, USR_STEP=1 for exactly one cycle, then DONE.
- LOAD: USR_PARALLEL_MODE=1, USR_PARALLEL_INPUT=latched data, USR_STEP=1 for one cycle, then DONE.
- SHIFT:
  - USR_STEP=1 and USR_SHIFT_RIGHT=latched direction.
  - USR_SERIAL_INPUT = latched CMD_SERIAL for SHIFT, or USR_SERIAL_OUT (combinational pass-through) for ROTATE.
  - REMAINING decrements each SHIFT cycle.
  - When REMAINING=1 at the edge -> DONE. Otherwise, free-run stays in SHIFT and step mode returns to SWAIT.
- SWAIT: USR_STEP=0. The registered SWITCH rising edge -> SHIFT.
- SWITCH conditioning: two-flop synchroniser, then edge detect against a third flop. The edge flag is registered, so a SWITCH toggle produces exactly one step 3–4 cycles later. Edges are consumed only in SWAIT; edges in any other state are discarded.
- DONE: DONE=1 for one cycle, BUSY=1, CMD_READY=0, REMAINING=0, then IDLE. Back-to-back commands are therefore separated by at least one DONE cycle.
- ABORT:
  - In SHIFT or SWAIT: -> IDLE next edge, no DONE pulse, REMAINING cleared. No USR_STEP is issued in the abort cycle.
  - ABORT and a SWITCH edge in the same SWAIT cycle: ABORT wins.
  - In other states ABORT is ignored.
- Outputs USR_PARALLEL_MODE, USR_CLR and USR_STEP are 0 in every state not listed above. USR_PARALLEL_INPUT holds the last latched data.
- Free-run latency: a shift of N accepted at edge 0 gives USR_STEP high for edges 1..N and DONE high in cycle N+1.
- Reset mid-command: immediate return to IDLE. No DONE, no further steps.

Test Plan:
- Reset, then LOAD CMD_DATA=4'b1011 -> one USR_STEP cycle with USR_PARALLEL_MODE=1 and USR_PARALLEL_INPUT=1011, DONE 2 cycles after acceptance, CMD_READY low for 2 cycles.
- Free-run SHIFT, right, count 3, serial 1 -> USR_STEP high for exactly 3 consecutive cycles, USR_SHIFT_RIGHT=1, USR_SERIAL_INPUT=1, REMAINING 3→2→1→0, DONE in cycle 4.
- ROTATE left count 4 with model register 1000 -> USR_SERIAL_INPUT tracks USR_SERIAL_OUT each step, register returns to 1000, DONE once.
- STEP_MODE=1 SHIFT count 2; toggle SWITCH (hold 5 cycles per level, including a glitch while IDLE) -> IDLE glitch ignored, exactly one USR_STEP per rising edge, DONE after the second edge.
- SHIFT count 0 -> no USR_STEP, DONE next cycle. CLEAR -> single cycle with USR_CLR=1 and USR_STEP=1.
- Free-run SHIFT count 7: ABORT after 2 steps -> IDLE, no DONE, REMAINING=0. Repeat with RST pulsed low mid-shift -> all outputs 0 immediately, CMD_READY=1 after release.
